// File: rtl/bcd_mul_seq.sv
// Iterative N-digit packed-BCD multiplier: one digit partial product and accumulate per clock.
// Optional operand digit checker enabled by defining BCD_MUL_CHK_EN.
module bcd_mul_seq #(
    parameter int unsigned N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*4-1:0]   a,
    input  logic [N*4-1:0]   b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N*4-1:0] p,
    output logic             busy,
    output logic             err
);

    localparam int unsigned W    = N * 4;
    localparam int unsigned PpW  = (N + 1) * 4;
    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} stateT;

    stateT           stateQ, stateD;
    logic [W-1:0]    aQ, aD;
    logic [W-1:0]    bQ, bD;
    logic [W-1:0]    accHiQ, accHiD;
    logic [W-1:0]    accLoQ, accLoD;
    logic [CntW-1:0] cntQ, cntD;
    logic [2*W-1:0]  pQ, pD;
    logic [PpW-1:0]  ppUnits, ppTens, pp, sum;

`ifdef BCD_MUL_CHK_EN
    logic            errQ, errD;
`endif

    // Single-digit product split into {tens, units}.
    function automatic logic [7:0] digitMul(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] prod;
        prod = 8'(x) * 8'(y);
        return {4'(prod / 8'd10), 4'(prod % 8'd10)};
    endfunction

    // Ripple BCD add over N+1 digits; callers guarantee no carry out of the top digit.
    function automatic logic [PpW-1:0] bcdAdd(input logic [PpW-1:0] x, input logic [PpW-1:0] y);
        logic [PpW-1:0] r;
        logic           carry;
        logic [4:0]     s;
        r     = '0;
        carry = 1'b0;
        for (int i = 0; i < int'(N + 1); i++) begin
            s     = {1'b0, x[i*4+:4]} + {1'b0, y[i*4+:4]} + {4'b0000, carry};
            carry = (s > 5'd9);
            if (carry) begin
                s = s + 5'd6;
            end
            r[i*4+:4] = s[3:0];
        end
        return r;
    endfunction

`ifdef BCD_MUL_CHK_EN
    function automatic logic hasNonBcd(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (x[i*4+:4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction
`endif

    // Partial product a*d: units land in place, tens shift up one digit, then merge.
    always_comb begin
        logic [7:0] dp;
        dp      = '0;
        ppUnits = '0;
        ppTens  = '0;
        for (int i = 0; i < int'(N); i++) begin
            dp                   = digitMul(aQ[i*4+:4], bQ[3:0]);
            ppUnits[i*4+:4]      = dp[3:0];
            ppTens[(i+1)*4+:4]   = dp[7:4];
        end
        pp  = bcdAdd(ppUnits, ppTens);
        sum = bcdAdd({4'h0, accHiQ}, pp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            aQ     <= '0;
            bQ     <= '0;
            accHiQ <= '0;
            accLoQ <= '0;
            cntQ   <= '0;
            pQ     <= '0;
`ifdef BCD_MUL_CHK_EN
            errQ   <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            aQ     <= aD;
            bQ     <= bD;
            accHiQ <= accHiD;
            accLoQ <= accLoD;
            cntQ   <= cntD;
            pQ     <= pD;
`ifdef BCD_MUL_CHK_EN
            errQ   <= errD;
`endif
        end
    end

    always_comb begin
        stateD = stateQ;
        aD     = aQ;
        bD     = bQ;
        accHiD = accHiQ;
        accLoD = accLoQ;
        cntD   = cntQ;
        pD     = pQ;
`ifdef BCD_MUL_CHK_EN
        errD   = errQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (in_valid) begin
                    aD     = a;
                    bD     = b;
                    accHiD = '0;
                    accLoD = '0;
                    cntD   = '0;
                    stateD = StMul;
`ifdef BCD_MUL_CHK_EN
                    if (hasNonBcd(a) || hasNonBcd(b)) begin
                        errD   = 1'b1;
                        pD     = '0;
                        stateD = StDone;
                    end
`endif
                end
            end
            StMul: begin
                if (abort) begin
                    stateD = StIdle;
                end else begin
                    // Low digit of the sum retires into accLo; the rest stays as running total.
                    accHiD = sum[PpW-1:4];
                    accLoD = {sum[3:0], accLoQ[W-1:4]};
                    bD     = bQ >> 4;
                    cntD   = cntQ + CntW'(1);
                    if (cntQ == CntW'(N - 1)) begin
                        stateD = StDone;
                        pD     = {accHiD, accLoD};
                    end
                end
            end
            StDone: begin
                // abort and the handshake both return to idle; p is left untouched either way.
                if (abort || out_ready) begin
                    stateD = StIdle;
`ifdef BCD_MUL_CHK_EN
                    errD   = 1'b0;
`endif
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign in_ready  = (stateQ == StIdle);
    assign out_valid = (stateQ == StDone);
    assign busy      = (stateQ != StIdle);
    assign p         = pQ;

`ifdef BCD_MUL_CHK_EN
    assign err = errQ;
`else
    assign err = 1'b0;
`endif

endmodule
